pipelined_carry_skip_add: RTL and testbench



---
 rtl/pipelined_carry_skip_add.sv | 122 ++++++++++++
 tb/tb_pipelined_carry_skip_add.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_add.sv
// pipelined_carry_skip_add: STAGES-deep pipelined carry-skip adder with valid/ready flow control.
// Ports: clk; rst_n (asynchronous, active-low);
//        in_valid/in_ready/a/b/ci  - operand side, accepted on in_valid & in_ready;
//        out_valid/out_ready/c/co/ovf - result side (sum, carry-out, signed overflow).
// Optional macro ADD_SUB_EN: adds input sub; sub=1 inverts b on entry (a + ~b + ci).
module pipelined_carry_skip_add #(
    parameter int N      = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
`ifdef ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co,
    output logic         ovf
);
    localparam int W = N / STAGES;

    // Returns {carry into bit W-1, segment carry-out, segment sum}.
    function automatic logic [W+1:0] seg_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        logic [W-1:0] s;
        logic cg, cr, cm;
        s  = '0;
        cg = cin;
        cr = cin;
        cm = cin;
        for (int g = 0; g < W / BLOCK; g++) begin
            cr = cg;
            for (int i = 0; i < BLOCK; i++) begin
                s[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i] ^ cr;
                cm = cr;
                cr = (x[g*BLOCK+i] & y[g*BLOCK+i]) | (cr & (x[g*BLOCK+i] ^ y[g*BLOCK+i]));
            end
            // A fully propagating group passes its carry-in straight through.
            cg = &(x[g*BLOCK +: BLOCK] ^ y[g*BLOCK +: BLOCK]) ? cg : cr;
        end
        return {cm, cg, s};
    endfunction

    logic         adv;
    logic [N-1:0] b_in;
    logic [N-1:0] ia [STAGES];
    logic [N-1:0] ib [STAGES];
    logic [N-1:0] sa [STAGES];
    logic [N-1:0] ns [STAGES];
    logic         ic [STAGES];
    logic         iv [STAGES];
    logic [W+1:0] r  [STAGES];
    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic         v_q [STAGES];
    logic         cy_q [STAGES];
    logic         ov_q [STAGES];

`ifdef ADD_SUB_EN
    assign b_in = sub ? ~b : b;
`else
    assign b_in = b;
`endif

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign c         = s_q[STAGES-1];
    assign co        = cy_q[STAGES-1];
    assign ovf       = ov_q[STAGES-1];

    // Stage k sees its predecessor's registers; stage 0 sees the ports.
    // Operands travel whole down the pipe so no stage re-reads a or b.
    always_comb begin
        ia[0] = a;
        ib[0] = b_in;
        sa[0] = '0;
        ic[0] = ci;
        iv[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            ia[k] = a_q[k-1];
            ib[k] = b_q[k-1];
            sa[k] = s_q[k-1];
            ic[k] = cy_q[k-1];
            iv[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            r[k]  = seg_add(ia[k][k*W +: W], ib[k][k*W +: W], ic[k]);
            ns[k] = sa[k];
            ns[k][k*W +: W] = r[k][W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                cy_q[k] <= 1'b0;
                ov_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= iv[k];
                a_q[k]  <= ia[k];
                b_q[k]  <= ib[k];
                s_q[k]  <= ns[k];
                cy_q[k] <= r[k][W];
                ov_q[k] <= r[k][W+1] ^ r[k][W];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_carry_skip_add.sv
// tb_pipelined_carry_skip_add: scoreboard bench for the pipelined carry-skip adder.
module tb_pipelined_carry_skip_add;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ci = 1'b0;
`ifdef ADD_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic        co;
    logic        ovf;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q [$];

    pipelined_carry_skip_add #(.N(32), .BLOCK(4), .STAGES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .ci(ci),
`ifdef ADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c(c),
        .co(co),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when out_valid & out_ready.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %h expected none", {c, co, ovf});
            end else begin
                check("result", {c, co, ovf}, exp_q.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                        input logic [31:0] ec, input logic eco, input logic eov);
        int n = 0;
        a = ta;
        b = tb;
        ci = tci;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back({ec, eco, eov});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {c, co, ovf}, 34'd0);
        check("reset_in_ready", {33'd0, in_ready}, 34'd1);
        check("reset_out_valid", {33'd0, out_valid}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full skip chain and latency: out_valid in cycle 4 after presentation in cycle 0
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            check("latency_early", {33'd0, out_valid}, 34'd0);
            @(negedge clk);
        end
        #1;
        check("latency_hit", {33'd0, out_valid}, 34'd1);
        @(negedge clk);
        drain();

        // Signed overflow cases
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        drain();

        // Eight back-to-back vectors
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0);
        send(32'hDEAD_BEEF, 32'h2152_4110, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        drain();

        // Fill the pipe with the output blocked, then stall three cycles
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        a = 32'h0000_0100;
        b = 32'h0000_0200;
        ci = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", {33'd0, in_ready}, 34'd0);
            check("stall_hold", {c, co, ovf}, exp_q[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0000_0300, 1'b0, 1'b0);
        drain();

`ifdef ADD_SUB_EN
        sub = 1'b1;
        send(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        sub = 1'b0;
        send(32'd7, 32'd5, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
        drain();
`endif

        // Asynchronous reset with a full, blocked pipe
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        send(32'h0000_0002, 32'h0000_0002, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0006, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1;
        check("full_before_reset", {33'd0, out_valid}, 34'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", {33'd0, out_valid}, 34'd0);
        check("async_reset_data", {c, co, ovf}, 34'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", {33'd0, in_ready}, 34'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_idle", {33'd0, out_valid}, 34'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(32'h0000_0009, 32'h0000_0006, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
